// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin scheduler/sequencer sharing one shift-add signed
// multiplier datapath between two requesters.
// Optional build macro: MULT_SKIP_ADD_EN -- when defined, an ADD step whose
// multiplier bit is 0 shifts immediately instead of idling, so each 0 bit costs
// one cycle and each 1 bit costs two.
module mult_share_sched #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [1:0]           Req,
  input  logic [WIDTH-1:0]     Op_A0,
  input  logic [WIDTH-1:0]     Op_B0,
  input  logic [WIDTH-1:0]     Op_A1,
  input  logic [WIDTH-1:0]     Op_B1,
  output logic [1:0]           Gnt,
  output logic [1:0]           Done,
  output logic [2*WIDTH-1:0]   Prod,
  output logic                 Dp_Load,
  output logic [WIDTH-1:0]     Dp_Opnd_S,
  output logic [WIDTH-1:0]     Dp_Opnd_B,
  output logic                 Dp_Add,
  output logic                 Dp_Sub,
  output logic                 Dp_Shift,
  input  logic                 Dp_M,
  input  logic [2*WIDTH-1:0]   Dp_Prod
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ptr_q, ptr_d;      // requester served last
  logic                      owner_q, owner_d;  // requester of the running product
  logic signed [WIDTH-1:0]   opnd_s_q, opnd_s_d;
  logic signed [WIDTH-1:0]   opnd_b_q, opnd_b_d;
  logic signed [2*WIDTH-1:0] prod_q, prod_d;
  logic                      win;

  assign Dp_Opnd_S = opnd_s_q;
  assign Dp_Opnd_B = opnd_b_q;
  assign Prod      = prod_q;

  // Next-state, arbitration and datapath strobe decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    opnd_s_d = opnd_s_q;
    opnd_b_d = opnd_b_q;
    prod_d   = prod_q;
    win      = 1'b0;
    Gnt      = 2'b00;
    Done     = 2'b00;
    Dp_Load  = 1'b0;
    Dp_Add   = 1'b0;
    Dp_Sub   = 1'b0;
    Dp_Shift = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A grant issued while Reset is high would be discarded, so suppress it.
        if (!Reset && (Req != 2'b00)) begin
          win      = (Req == 2'b11) ? ~ptr_q : Req[1];
          Gnt      = win ? 2'b10 : 2'b01;
          opnd_s_d = win ? $signed(Op_A1) : $signed(Op_A0);
          opnd_b_d = win ? $signed(Op_B1) : $signed(Op_B0);
          owner_d  = win;
          ptr_d    = win;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        Dp_Load = 1'b1;
        cnt_d   = '0;
        state_d = S_ADD;
      end
      S_ADD: begin
        if (Dp_M) begin
          // The top multiplier bit carries negative weight in two's complement.
          if (cnt_q == CNT_LAST) Dp_Sub = 1'b1;
          else                   Dp_Add = 1'b1;
          state_d = S_SHIFT;
        end else begin
`ifdef MULT_SKIP_ADD_EN
          Dp_Shift = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_ADD;
          end
`else
          state_d = S_SHIFT;
`endif
        end
      end
      S_SHIFT: begin
        Dp_Shift = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        prod_d  = $signed(Dp_Prod);
        Done    = owner_q ? 2'b10 : 2'b01;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, pointer and operand/product registers; reset aborts any operation.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= 1'b1;
      owner_q  <= 1'b0;
      opnd_s_q <= '0;
      opnd_b_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      opnd_s_q <= opnd_s_d;
      opnd_b_q <= opnd_b_d;
      prod_q   <= prod_d;
    end
  end

endmodule
